fp16_div_unit: RTL and testbench

FP16_DIV_UNIT -- requirements
Module: fp16_div_unit

---
 rtl/fp16_pkg.sv | 23 ++
 rtl/fp16_div_step.sv | 20 ++
 rtl/fp16_div_unit.sv | 165 ++++++++++++++++
 tb/tb_fp16_div_unit.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// Shared FP16 field layout, exponent constants and the divider state encoding.
package fp16_pkg;

   localparam int EXP_W     = 5;
   localparam int FRAC_W    = 10;
   localparam int BIAS      = 15;
   localparam int EXP_MAX   = 31;
   localparam int DIV_ITERS = 12;

   localparam int SIGN_BIT  = 15;
   localparam int EXP_MSB   = 14;
   localparam int EXP_LSB   = 10;
   localparam int FRAC_MSB  = 9;
   localparam int FRAC_LSB  = 0;

   typedef enum logic [1:0] {
      IDLE,
      DIVIDE,
      NORM,
      DONE
   } div_state_t;

endpackage

// File: rtl/fp16_div_step.sv
// One restoring-division iteration: conditional subtract of the divisor, then shift left.
module fp16_div_step
   import fp16_pkg::*;
(
   input  logic [FRAC_W+1:0] rem,
   input  logic [FRAC_W:0]   mb,
   output logic [FRAC_W+1:0] next_rem,
   output logic              q_bit
);

   logic [FRAC_W+1:0] diff;

   // The remainder stays below 2*mb, so the shifted value always fits in 12 bits.
   always_comb begin
      q_bit    = (rem >= {1'b0, mb});
      diff     = q_bit ? (rem - {1'b0, mb}) : rem;
      next_rem = diff << 1;
   end

endmodule

// File: rtl/fp16_div_unit.sv
// Multi-cycle FP16 divider: captures operands, runs 12 restoring iterations, normalises with truncation.
module fp16_div_unit
   import fp16_pkg::*;
#(
   parameter int DATA_WIDTH = 16
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  div_by_zero
);

   localparam logic [3:0]        LAST_ITER = 4'(DIV_ITERS);
   localparam logic signed [7:0] BIAS_S    = 8'(BIAS);
   localparam logic signed [7:0] EXP_MAX_S = 8'(EXP_MAX);
   localparam logic [EXP_W-1:0]  EXP_ONES  = '1;

   div_state_t state;
   div_state_t state_next;

   logic [DATA_WIDTH-1:0] a_reg;
   logic [DATA_WIDTH-1:0] b_reg;
   logic [FRAC_W+1:0]     rem;
   logic [FRAC_W+1:0]     q;
   logic [3:0]            iter;

   logic [FRAC_W:0]       mb;
   logic [FRAC_W+1:0]     step_rem;
   logic                  step_bit;

   logic                  sign;
   logic                  a_zero;
   logic                  b_zero;
   logic signed [7:0]     ea_s;
   logic signed [7:0]     eb_s;
   logic signed [7:0]     exp_prov;
   logic signed [7:0]     exp_norm;
   logic [FRAC_W-1:0]     frac_norm;
   logic [DATA_WIDTH-1:0] result_next;
   logic                  dbz_next;

   assign mb = {1'b1, b_reg[FRAC_MSB:FRAC_LSB]};

   fp16_div_step u_step (
      .rem      (rem),
      .mb       (mb),
      .next_rem (step_rem),
      .q_bit    (step_bit)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      busy       = 1'b1;
      done       = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_next = DIVIDE;
            end
         end
         DIVIDE: begin
            if (iter == LAST_ITER) begin
               state_next = NORM;
            end
         end
         NORM: begin
            state_next = DONE;
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // The first DIVIDE cycle only seeds the remainder; iterations 1..12 each retire one quotient bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         a_reg       <= '0;
         b_reg       <= '0;
         rem         <= '0;
         q           <= '0;
         iter        <= '0;
         result      <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_reg <= a;
                  b_reg <= b;
                  iter  <= '0;
               end
            end
            DIVIDE: begin
               if (iter == 4'd0) begin
                  rem <= {1'b0, 1'b1, a_reg[FRAC_MSB:FRAC_LSB]};
                  q   <= '0;
               end else begin
                  rem <= step_rem;
                  q   <= {q[FRAC_W:0], step_bit};
               end
               iter <= iter + 4'd1;
            end
            NORM: begin
               result      <= result_next;
               div_by_zero <= dbz_next;
            end
            default: begin
            end
         endcase
      end
   end

   // Quotient lies in [0.5, 2); a clear top bit means one extra left shift and exponent decrement.
   always_comb begin
      sign   = a_reg[SIGN_BIT] ^ b_reg[SIGN_BIT];
      a_zero = (a_reg[EXP_MSB:EXP_LSB] == '0);
      b_zero = (b_reg[EXP_MSB:EXP_LSB] == '0);
      ea_s   = {3'b000, a_reg[EXP_MSB:EXP_LSB]};
      eb_s   = {3'b000, b_reg[EXP_MSB:EXP_LSB]};
      exp_prov = ea_s - eb_s + BIAS_S;

      if (q[FRAC_W+1]) begin
         frac_norm = q[FRAC_W:1];
         exp_norm  = exp_prov;
      end else begin
         frac_norm = q[FRAC_W-1:0];
         exp_norm  = exp_prov - 8'sd1;
      end

      dbz_next    = 1'b0;
      result_next = '0;
      if (b_zero) begin
         dbz_next    = 1'b1;
         result_next = {sign, EXP_ONES, {FRAC_W{1'b0}}};
      end else if (a_zero) begin
         result_next = '0;
      end else if (exp_norm >= EXP_MAX_S) begin
         result_next = {sign, EXP_ONES, {FRAC_W{1'b0}}};
      end else if (exp_norm <= 8'sd0) begin
         result_next = '0;
      end else begin
         result_next = {sign, 5'(exp_norm), frac_norm};
      end
   end

endmodule

// File: tb/tb_fp16_div_unit.sv
// Scoreboard bench for fp16_div_unit: directed and random divisions against an arithmetic reference.
module tb_fp16_div_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        busy;
   logic        done;
   logic [15:0] result;
   logic        div_by_zero;

   typedef struct {
      logic [15:0] res;
      logic        dbz;
      int          due;
   } expect_t;

   expect_t sb_q[$];
   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   fp16_div_unit #(.DATA_WIDTH(16)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done        (done),
      .result      (result),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] required);
      checks++;
      if (actual !== required) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, required, cyc);
      end
   endtask

   // Reference: exact integer quotient of the 11-bit significands, then truncating normalisation.
   function automatic logic [16:0] ref_div(input logic [15:0] x, input logic [15:0] y);
      logic       s;
      int         ex, ey, mx, my, quo, e, frac;
      logic [4:0] ef;
      logic [9:0] ff;
      s  = x[15] ^ y[15];
      ex = int'(x[14:10]);
      ey = int'(y[14:10]);
      if (ey == 0) return {1'b1, s, 5'h1F, 10'h000};
      if (ex == 0) return 17'h0;
      mx   = 1024 + int'(x[9:0]);
      my   = 1024 + int'(y[9:0]);
      quo  = (mx * 2048) / my;
      e    = ex - ey + 15;
      if (quo >= 2048) begin
         frac = (quo / 2) % 1024;
      end else begin
         frac = quo % 1024;
         e    = e - 1;
      end
      if (e >= 31) return {1'b0, s, 5'h1F, 10'h000};
      if (e <= 0)  return 17'h0;
      ef = e[4:0];
      ff = frac[9:0];
      return {1'b0, s, ef, ff};
   endfunction

   always @(negedge clk) begin
      expect_t e;
      if (done) begin
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_done: got done=1, expected done=0 (cycle %0d)", cyc);
         end else begin
            e = sb_q.pop_front();
            check_output("result", 32'(result), 32'(e.res));
            check_output("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
            check_output("latency", 32'(cyc), 32'(e.due));
         end
      end
   end

   task automatic wait_done();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 24 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      check_output("done_seen", 32'(seen), 32'd1);
   endtask

   task automatic apply_stimulus(input logic [15:0] ta, input logic [15:0] tb_in,
                                 input logic [15:0] er, input logic ed, input bit noisy);
      expect_t e;
      @(negedge clk);
      a     = ta;
      b     = tb_in;
      start = 1'b1;
      e.res = er;
      e.dbz = ed;
      e.due = cyc + 15;
      sb_q.push_back(e);
      @(negedge clk);
      check_output("busy_after_start", 32'(busy), 32'd1);
      start = 1'b0;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         if (noisy) begin
            a     = 16'($urandom);
            b     = 16'($urandom);
            start = 1'($urandom_range(0, 1));
         end
      end
      @(negedge clk);
      start = 1'b0;
      wait_done();
   endtask

   logic [15:0] dir_a   [8] = '{16'h3C00, 16'h4600, 16'h3C00, 16'hC000, 16'h3C00, 16'h0000, 16'h7800, 16'h0400};
   logic [15:0] dir_b   [8] = '{16'h3C00, 16'h4000, 16'h4200, 16'h3800, 16'h0000, 16'h4000, 16'h0400, 16'h7800};
   logic [15:0] dir_res [8] = '{16'h3C00, 16'h4200, 16'h3555, 16'hC400, 16'h7C00, 16'h0000, 16'h7C00, 16'h0000};
   logic        dir_dbz [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [15:0] ra, rb;
      logic [16:0] rm;
      expect_t     e;
      bit          seen;

      reset = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      repeat (3) @(negedge clk);
      check_output("reset_busy", 32'(busy), 32'd0);
      check_output("reset_done", 32'(done), 32'd0);
      check_output("reset_result", 32'(result), 32'h0);
      check_output("reset_dbz", 32'(div_by_zero), 32'd0);
      a     = 16'h3C00;
      b     = 16'h3C00;
      start = 1'b1;
      @(negedge clk);
      check_output("reset_over_start", 32'(busy), 32'd0);
      reset = 1'b0;
      start = 1'b0;

      $display("[TB] directed vectors");
      for (int i = 0; i < 8; i++) begin
         apply_stimulus(dir_a[i], dir_b[i], dir_res[i], dir_dbz[i], 1'b0);
      end

      $display("[TB] start held high with changing operands");
      @(negedge clk);
      a     = 16'h4600;
      b     = 16'h4000;
      start = 1'b1;
      e.res = 16'h4200;
      e.dbz = 1'b0;
      e.due = cyc + 15;
      sb_q.push_back(e);
      seen = 1'b0;
      for (int i = 0; i < 24 && !seen; i++) begin
         @(negedge clk);
         if (done) begin
            seen  = 1'b1;
            start = 1'b0;
         end else begin
            a = 16'($urandom);
            b = 16'($urandom);
         end
      end
      start = 1'b0;
      check_output("held_done_seen", 32'(seen), 32'd1);
      @(negedge clk);
      check_output("held_idle_busy", 32'(busy), 32'd0);
      repeat (20) @(negedge clk);

      $display("[TB] reset in the middle of an operation");
      a     = 16'h3C00;
      b     = 16'h4200;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_output("abort_busy", 32'(busy), 32'd0);
      check_output("abort_done", 32'(done), 32'd0);
      check_output("abort_result", 32'(result), 32'h0);
      check_output("abort_dbz", 32'(div_by_zero), 32'd0);
      reset = 1'b0;
      a     = 16'hC000;
      b     = 16'h3800;
      start = 1'b1;
      e.res = 16'hC400;
      e.dbz = 1'b0;
      e.due = cyc + 15;
      sb_q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      check_output("post_reset_busy", 32'(busy), 32'd1);
      wait_done();

      $display("[TB] randomized operands");
      for (int i = 0; i < 40; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         if ($urandom_range(0, 7) == 0) ra[14:10] = 5'd0;
         if ($urandom_range(0, 7) == 0) rb[14:10] = 5'd0;
         if ($urandom_range(0, 5) == 0) ra[14:10] = 5'($urandom_range(26, 31));
         if ($urandom_range(0, 5) == 0) rb[14:10] = 5'($urandom_range(1, 5));
         rm = ref_div(ra, rb);
         apply_stimulus(ra, rb, rm[15:0], rm[16], 1'b1);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(negedge clk);
      check_output("queue_drained", 32'(sb_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
